// File: rtl/crc_pkg.sv
// Shared CRC definitions for the serial LFSR stage and its downstream checker.
package crc_pkg;

  localparam int unsigned CRC_WIDTH     = 8;
  localparam int unsigned DEFAULT_CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } crc_state_e;

endpackage : crc_pkg

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; used for the pass and fail tallies.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INC,
  output logic [CNT_W-1:0] COUNT
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (INC && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign COUNT = count_q;

endmodule : sat_counter

// File: rtl/crc_serial_checker.sv
// Assembles an LSB-first serial CRC into a word, compares it against the
// expected value latched on the first bit, and keeps pass/fail tallies.
module crc_serial_checker
  import crc_pkg::*;
#(
  parameter int unsigned WIDTH = CRC_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CRC_IN,
  input  logic             VALID_IN,
  input  logic [WIDTH-1:0] EXP_CRC,
  output logic [WIDTH-1:0] CRC_OUT,
  output logic             DONE,
  output logic             MATCH,
  output logic             ERR,
  output logic             BUSY,
  output logic [CNT_W-1:0] PASS_CNT,
  output logic [CNT_W-1:0] FAIL_CNT
);

  localparam int unsigned BIT_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);

  crc_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     sreg_q, sreg_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic [WIDTH-1:0]     crc_out_q, crc_out_d;
  logic                 match_q, match_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     sreg_shift_c;

  assign sreg_shift_c = {CRC_IN, sreg_q[WIDTH-1:1]};

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    exp_d     = exp_q;
    crc_out_d = crc_out_q;
    match_d   = match_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (VALID_IN) begin
          sreg_d  = sreg_shift_c;
          exp_d   = EXP_CRC;
          cnt_d   = BIT_CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (VALID_IN) begin
          sreg_d = sreg_shift_c;
          if (cnt_q == LAST_BIT) begin
            crc_out_d = sreg_shift_c;
            match_d   = (sreg_shift_c == exp_q);
            done_d    = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + BIT_CNT_W'(1);
          end
        end else begin
          // Valid dropped before the last bit: abandon the frame
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sreg_q    <= '0;
      exp_q     <= '0;
      crc_out_q <= '0;
      match_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      exp_q     <= exp_d;
      crc_out_q <= crc_out_d;
      match_q   <= match_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .INC   (done_d && match_d),
    .COUNT (PASS_CNT)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .INC   (done_d && !match_d),
    .COUNT (FAIL_CNT)
  );

  assign CRC_OUT = crc_out_q;
  assign DONE    = done_q;
  assign MATCH   = match_q;
  assign ERR     = err_q;
  assign BUSY    = busy_q;

endmodule : crc_serial_checker

// File: doc/crc_serial_checker.md
Name: crc_serial_checker

Overview:
Downstream consumer of the serial CRC LFSR stage. Captures the LSB-first CRC bitstream the LFSR emits while its Valid is high and assembles it into a parallel word. Compares the word against an expected CRC and reports the result. Keeps saturating pass/fail tallies for self-checking and in-system frame checking.

Parameters:
WIDTH, 8, CRC width in bits; must be >= 2.
CNT_W, 8, width of the pass/fail counters.

Ports:
CLK  input  1  single clock; all logic is on the rising edge.
RST  input  1  synchronous, active-high reset.
CRC_IN  input  1  serial CRC bit from the LFSR stage, LSB first.
VALID_IN  input  1  LFSR Valid; high for exactly WIDTH consecutive cycles per frame.
EXP_CRC  input  WIDTH  expected CRC; sampled on the first bit of each frame.
CRC_OUT  output  WIDTH  last fully assembled CRC word; held until the next completed frame.
DONE  output  1  one-cycle pulse on frame completion.
MATCH  output  1  CRC_OUT == latched EXP_CRC; valid from DONE, held until the next DONE.
ERR  output  1  one-cycle pulse when a frame is truncated.
BUSY  output  1  high while in SHIFT.
PASS_CNT  output  CNT_W  saturating count of matching frames.
FAIL_CNT  output  CNT_W  saturating count of mismatching frames.

Behaviour:
- Reset (sync, RST=1 at a rising edge): state=IDLE; bit counter=0; shift register=0; latched expected=0; CRC_OUT=0, DONE=0, MATCH=0, ERR=0, BUSY=0, PASS_CNT=0, FAIL_CNT=0. RST takes priority over all other activity.
- Reset mid-frame: the frame is silently discarded; no DONE, no ERR.
- Shift register update: sreg <= {CRC_IN, sreg[WIDTH-1:1]}. After WIDTH samples, sreg[0] holds the first bit received.
- IDLE:
  - VALID_IN=1: sample bit 0, latch EXP_CRC, cnt<=1, go to SHIFT.
  - VALID_IN=0: stay in IDLE.
- SHIFT, VALID_IN=1, cnt < WIDTH-1: sample the bit, cnt<=cnt+1.
- SHIFT, VALID_IN=1, cnt == WIDTH-1 (last bit): at this edge:
  - CRC_OUT <= assembled word including this bit.
  - MATCH <= (that word == latched expected).
  - DONE <= 1.
  - PASS_CNT or FAIL_CNT increments, saturating at 2^CNT_W-1.
  - cnt<=0, go to IDLE.
- Latency: DONE is high in the cycle immediately after the edge that captured bit WIDTH-1, i.e. WIDTH cycles after the first sample edge.
- SHIFT, VALID_IN=0 (truncated frame): ERR <= 1 for one cycle; go to IDLE, cnt<=0. CRC_OUT, MATCH and both counters are unchanged.
- Back-to-back frames: if VALID_IN stays high past bit WIDTH-1, the next bit is taken in IDLE as bit 0 of a new frame. There are no idle cycles required between frames. DONE for frame N and bit 0 of frame N+1 may coincide.
- DONE and ERR are never high in the same cycle. Both deassert the cycle after they pulse.
- EXP_CRC changes mid-frame are ignored.
- BUSY = (state == SHIFT), registered with the state.
- Counters hold at all-ones once saturated.

Decomposition:
- Shared package crc_pkg:
  - CRC_WIDTH = 8, also used by the LFSR stage.
  - State enum {IDLE, SHIFT}.
  - Default CNT_W.
- One natural sub-module, sat_counter (parameter CNT_W; inputs CLK, RST, INC; output COUNT). Instantiated twice, for pass and fail.

Test Plan:
- Frame match: RST, then send 0xA5 LSB-first (1,0,1,0,0,1,0,1) with VALID_IN high 8 cycles and EXP_CRC=0xA5 → DONE pulses once 8 cycles after the first sample; CRC_OUT=0xA5, MATCH=1, PASS_CNT=1, FAIL_CNT=0.
- Frame mismatch: send 0x3C with EXP_CRC=0x3D → CRC_OUT=0x3C, MATCH=0, FAIL_CNT=1, PASS_CNT unchanged.
- Truncation: VALID_IN high 5 cycles then low → ERR pulses one cycle, no DONE; CRC_OUT and counters retain prior values; BUSY returns to 0.
- Back-to-back: two frames 0x01 then 0xFF with VALID_IN high 16 continuous cycles, EXP_CRC 0x01 then 0xFF (changed on bit 0 of frame 2) → two DONE pulses 8 cycles apart; CRC_OUT 0x01 then 0xFF; PASS_CNT=2.
- Reset mid-frame: RST=1 for one cycle after 3 bits → all outputs 0; no DONE or ERR. A following full 0x5A frame yields CRC_OUT=0x5A.
- Saturation (CNT_W=2): five matching frames → PASS_CNT sequence 1,2,3,3,3.
